// File: rtl/lightning_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lightning_axis_pkg
// Purpose  : Shared FSM encoding and probe constants for the AXIS delay
//            calibrator.
// Revision : 1.0 - initial release
// ============================================================================
package lightning_axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_WAIT  = 2'd2
  } cal_state_e;

  // Probe beats are built by replicating this word across the data bus.
  localparam logic [15:0] PROBE_WORD = 16'hA5C3;

  localparam int AVG_ROUNDS = 4;

endpackage : lightning_axis_pkg
`default_nettype wire

// File: rtl/axis_probe_matcher.sv
`default_nettype none
// ============================================================================
// Module   : axis_probe_matcher
// Purpose  : Combinational detector for a returning probe beat
//            (valid, last and data equal to the probe pattern).
// Revision : 1.0 - initial release
// ============================================================================
module axis_probe_matcher
  import lightning_axis_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 256,
  parameter logic [DATA_WIDTH-1:0] PROBE_PATTERN = {DATA_WIDTH/16{PROBE_WORD}}
) (
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  match
);

  assign match = s_axis_tvalid && s_axis_tlast && (s_axis_tdata == PROBE_PATTERN);

endmodule : axis_probe_matcher
`default_nettype wire

// File: rtl/axis_delay_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : axis_delay_calibrator
// Purpose  : Emits a single probe beat and measures the cycles until it
//            returns on the loopback stream; reports latency or timeout.
//            Optional macro DELAY_CAL_AVG_EN averages four rounds per start.
// Revision : 1.0 - initial release
// ============================================================================
module axis_delay_calibrator
  import lightning_axis_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 256,
  parameter logic [DATA_WIDTH-1:0] PROBE_PATTERN = {DATA_WIDTH/16{PROBE_WORD}},
  parameter int                    MAX_WAIT      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic [15:0]           delay_count,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam logic [15:0] MAX_WAIT_CNT = 16'(MAX_WAIT);

  cal_state_e            state_q, state_d;
  logic [15:0]           counter_q, counter_d;
  logic [15:0]           delay_count_q, delay_count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  match_w;

`ifdef DELAY_CAL_AVG_EN
  localparam logic [1:0] LAST_ROUND = 2'(AVG_ROUNDS - 1);

  logic [1:0]  round_q, round_d;
  logic [17:0] sum_q, sum_d;
  logic [17:0] sum_plus_w;

  assign sum_plus_w = sum_q + {2'b00, counter_q};
`endif

  axis_probe_matcher #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PROBE_PATTERN(PROBE_PATTERN)
  ) u_matcher (
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .match        (match_w)
  );

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    delay_count_d = delay_count_q;
    done_d        = 1'b0;
    timeout_d     = 1'b0;
`ifdef DELAY_CAL_AVG_EN
    round_d       = round_q;
    sum_d         = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PROBE;
`ifdef DELAY_CAL_AVG_EN
          round_d = 2'd0;
          sum_d   = 18'd0;
`endif
        end
      end

      // A beat returning in the probe cycle itself is never sampled here.
      ST_PROBE: begin
        counter_d = 16'd1;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        if (match_w) begin
`ifdef DELAY_CAL_AVG_EN
          if (round_q == LAST_ROUND) begin
            delay_count_d = sum_plus_w[17:2];
            done_d        = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            sum_d   = sum_plus_w;
            round_d = round_q + 2'd1;
            state_d = ST_PROBE;
          end
`else
          delay_count_d = counter_q;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
`endif
        end else if (counter_q == MAX_WAIT_CNT) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          counter_d = counter_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    busy_d     = (state_d != ST_IDLE);
    m_tvalid_d = (state_d == ST_PROBE);
    m_tlast_d  = (state_d == ST_PROBE);
    m_tdata_d  = (state_d == ST_PROBE) ? PROBE_PATTERN : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      counter_q     <= 16'd0;
      delay_count_q <= 16'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tdata_q     <= '0;
`ifdef DELAY_CAL_AVG_EN
      round_q       <= 2'd0;
      sum_q         <= 18'd0;
`endif
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      delay_count_q <= delay_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tdata_q     <= m_tdata_d;
`ifdef DELAY_CAL_AVG_EN
      round_q       <= round_d;
      sum_q         <= sum_d;
`endif
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign delay_count   = delay_count_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout       = timeout_q;

endmodule : axis_delay_calibrator
`default_nettype wire

// File: tb/tb_axis_delay_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_delay_calibrator
// Purpose  : Randomized loopback bench with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_delay_calibrator;

  localparam int DW = 64;
  localparam int MW = 16;
  localparam logic [DW-1:0] PAT = {DW/16{16'hA5C3}};

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [15:0]   delay_count;
  logic          busy;
  logic          done;
  logic          timeout;

  axis_delay_calibrator #(
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .delay_count  (delay_count),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Loopback: a chain of registers whose tap selects the loop depth
  // (depth 0 = direct wire), with optional junk beats overriding it.
  logic [DW+1:0] pipe [0:31];
  int            loop_depth = 1;
  logic          inj_en = 1'b0;
  logic [DW+1:0] inj_beat = '0;
  logic [DW+1:0] s_beat;

  always @(posedge clk) begin
    pipe[0] <= {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
    for (int i = 1; i < 32; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    s_beat = '0;
    if (inj_en)               s_beat = inj_beat;
    else if (loop_depth == 0) s_beat = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
    else                      s_beat = pipe[loop_depth-1];
  end

  assign s_axis_tvalid = s_beat[DW+1];
  assign s_axis_tlast  = s_beat[DW];
  assign s_axis_tdata  = s_beat[DW-1:0];

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [15:0] dly;
    longint      cyc;
    int          busy_len;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          probe_seen = 0;
  int          busy_run = 0;
  logic [15:0] last_delay = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks the probe port every cycle and pops the scoreboard on results.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (m_axis_tvalid) begin
        probe_seen++;
        chk("probe_tdata", m_axis_tdata, PAT);
        chk("probe_tlast", 64'(m_axis_tlast), 64'd1);
      end else begin
        chk("idle_tdata", m_axis_tdata, 64'd0);
        chk("idle_tlast", 64'(m_axis_tlast), 64'd0);
      end
      if (done || timeout) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result done=%0b timeout=%0b expected=none at cycle %0d",
                   done, timeout, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_pulse", 64'(done), 64'(e.is_done));
          chk("timeout_pulse", 64'(timeout), 64'(!e.is_done));
          chk("delay_count", 64'(delay_count), 64'(e.dly));
          chk("result_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_length", 64'(busy_run), 64'(e.busy_len));
          chk("busy_low_at_result", 64'(busy), 64'd0);
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end
    end
  end

  task automatic wait_idle_flush();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    repeat (34) @(negedge clk);
  endtask

  function automatic logic [DW+1:0] junk_beat();
    logic [DW-1:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0:       return {1'b1, 1'b0, PAT};
      1:       return {1'b1, 1'b1, PAT ^ (r | 64'd1)};
      default: return {1'b0, 1'b1, PAT};
    endcase
  endfunction

  // One measurement: the model predicts the outcome purely from loop depth.
  task automatic run_meas(input int depth, input int junk_pct);
    longint s;
    int     pc0;
    exp_t   e;
    bit     finished;
    loop_depth = depth;
    wait_idle_flush();
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    pc0 = probe_seen;
    if (depth >= 1 && depth <= MW) begin
      e = '{1'b1, 16'(depth), s + depth + 2, depth + 1};
      last_delay = 16'(depth);
    end else begin
      e = '{1'b0, last_delay, s + MW + 2, MW + 1};
    end
    sb_q.push_back(e);
    finished = 1'b0;
    for (int k = 1; k < MW + 40; k++) begin
      @(negedge clk);
      start  = 1'b0;
      inj_en = 1'b0;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (!(depth >= 1 && k == depth + 1) && $urandom_range(0, 99) < junk_pct) begin
        inj_beat = junk_beat();
        inj_en   = 1'b1;
      end
      start = ($urandom_range(0, 3) == 0);
    end
    start  = 1'b0;
    inj_en = 1'b0;
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL measurement_bound busy=%0b expected=0 depth=%0d", busy, depth);
    end
    chk("probe_count", 64'(probe_seen - pc0), 64'd1);
  endtask

  task automatic run_reset_abort();
    loop_depth = 20;
    wait_idle_flush();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_abort", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_timeout", 64'(timeout), 64'd0);
    chk("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("abort_tlast", 64'(m_axis_tlast), 64'd0);
    chk("abort_tdata", m_axis_tdata, 64'd0);
    chk("abort_delay", 64'(delay_count), 64'd0);
    rst = 1'b0;
    last_delay = 16'd0;
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_timeout", 64'(timeout), 64'd0);
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_tdata", m_axis_tdata, 64'd0);
    chk("reset_delay", 64'(delay_count), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_during_rst_ignored", 64'(busy), 64'd0);

    run_meas(7, 0);
    run_meas(1, 0);
    run_meas(0, 0);
    run_meas(12, 100);
    run_meas(7, 30);
    run_meas(20, 40);
    run_meas(16, 20);
    run_meas(17, 20);
    run_reset_abort();
    run_meas(9, 0);
    for (int n = 0; n < 30; n++) run_meas($urandom_range(0, 20), $urandom_range(0, 60));

    wait_idle_flush();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axis_delay_calibrator
`default_nettype wire

// File: doc/axis_delay_calibrator.md
AXIS_DELAY_CALIBRATOR -- requirements
Module: axis_delay_calibrator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, giving the probe/return beat width.
REQ-002 SHALL have parameter PROBE_PATTERN, default {DATA_WIDTH/16{16'hA5C3}}, giving the probe beat content.
REQ-003 SHALL have parameter MAX_WAIT, default 1024, giving the timeout in cycles (range 2..65535).
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit, a one-cycle request to begin a measurement.
REQ-007 SHALL have ports m_axis_tdata/m_axis_tvalid/m_axis_tlast, outputs, DATA_WIDTH/1/1 bits, carrying the probe beat toward the loop under test.
REQ-008 SHALL have ports s_axis_tdata/s_axis_tvalid/s_axis_tlast, inputs, DATA_WIDTH/1/1 bits, carrying the returning stream; the interface has no tready.
REQ-009 SHALL have port delay_count, output, 16 bits, the last measured loop latency in cycles.
REQ-010 SHALL have ports busy, done and timeout, outputs, 1 bit each: busy is a level; done and timeout are one-cycle pulses.

Function
REQ-011 SHALL implement the states IDLE, PROBE and WAIT.
REQ-012 SHALL move IDLE->PROBE on start=1; start SHALL be ignored in PROBE and WAIT.
REQ-013 SHALL, in PROBE (exactly one cycle), drive m_axis_tvalid=1, m_axis_tlast=1 and m_axis_tdata=PROBE_PATTERN, load the cycle counter with 1, and go to WAIT.
REQ-014 SHALL, outside PROBE, drive m_axis_tvalid=0, m_axis_tlast=0 and m_axis_tdata=0.
REQ-015 SHALL, in WAIT, declare a match when s_axis_tvalid=1, s_axis_tlast=1 and s_axis_tdata==PROBE_PATTERN; non-matching beats SHALL be ignored.
REQ-016 SHALL, on a match in WAIT, register delay_count<=counter, pulse done for one cycle in the following cycle, and return to IDLE.
REQ-017 SHALL ignore any return beat that arrives during the PROBE cycle, so the minimum reportable delay is 1.
REQ-018 SHALL, in WAIT without a match, increment the counter; when counter==MAX_WAIT with no match, it SHALL pulse timeout, leave delay_count unchanged, and return to IDLE.
REQ-019 SHALL give a match priority over timeout when both occur in the same cycle.
REQ-020 SHALL assert busy in PROBE and WAIT, and deassert it in IDLE, including during the cycle in which done or timeout is pulsed.
REQ-021 SHALL produce a result N for a probe emitted at cycle P that matches at cycle P+N, which equals the register depth of a pure-register loop.

Reset
REQ-022 SHALL, on rst=1, force state IDLE, counter=0, delay_count=0, and busy, done, timeout, m_axis_tvalid, m_axis_tlast and m_axis_tdata all 0.
REQ-023 SHALL, on rst asserted mid-measurement, abort with no done or timeout pulse, and SHALL ignore start during rst.

Configuration
REQ-024 SHALL, when macro DELAY_CAL_AVG_EN is defined, run 4 consecutive PROBE/WAIT rounds per start, accumulate the 4 results in an 18-bit sum, and report delay_count=sum>>2 (floor) with a single done pulse after the fourth match.
REQ-025 SHALL, with DELAY_CAL_AVG_EN defined, abort all rounds on a timeout in any round, pulse timeout once, and leave delay_count unchanged.
REQ-026 SHALL, without DELAY_CAL_AVG_EN, perform a single round per start and include no accumulator logic.

Structure
REQ-027 SHALL place the state encoding (IDLE/PROBE/WAIT), the default probe pattern constant and the round count of 4 in a shared package, lightning_axis_pkg.
REQ-028 SHALL instantiate one sub-module, axis_probe_matcher, which is combinational and compares the return beat's data, valid and last against PROBE_PATTERN; the FSM, counter and accumulator SHALL remain in the top module.

Verification
REQ-029 Loopback through 7 register stages, start pulsed -> single probe beat, done after the match, delay_count=7, busy high 8 cycles.
REQ-030 Loopback through 1 stage -> delay_count=1; a direct wire loopback (match during PROBE) -> timeout after MAX_WAIT cycles, delay_count unchanged.
REQ-031 Return stream carrying non-matching valid beats before the true probe at depth 12 -> delay_count=12; a beat with matching data but tlast=0 is ignored.
REQ-032 No return, with MAX_WAIT=16 -> timeout pulse exactly when counter reaches 16, previous delay_count 7 retained, start pulses while busy ignored.
REQ-033 rst asserted at WAIT counter=5 -> all outputs 0 the next cycle, no done or timeout pulse; a new start afterward measures correctly.
REQ-034 With DELAY_CAL_AVG_EN defined and loop depths 5, 6, 6, 6 per round -> one done pulse, delay_count=5 (23>>2).
